// File: rtl/alu_issue_if.sv
// Handshake and operand bus between the alu_issue stage, its upstream decode feed and the ALU/EX consumer.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [4:0]  rd;
  logic        is_branch;
  logic        illegal;

  modport master (
    input  in_valid, inst, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, alu_ctrl, alu_in1, alu_in2, rd, is_branch, illegal
  );

  modport slave (
    output in_valid, inst, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, alu_ctrl, alu_in1, alu_in2, rd, is_branch, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I ALU issue stage: decode to ALU op/operands, then a 2-entry valid/ready buffer.
// Optional macro ALU_LUI_PASS_EN: LUI issues PASS-B (16) instead of ADD with in1 = 0.
module alu_issue #(
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  alu_issue_if.master   bus
);
  typedef struct packed {
    logic [4:0]  ctrl;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  rd;
    logic        br;
    logic        ill;
  } entry_t;

  localparam logic [1:0] FULL = 2'(DEPTH);

  entry_t     dec, slot0, slot1;
  logic [1:0] count, count_nx;
  logic       in_ready_q, push, pop;

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_u, shamt;

  assign opcode = bus.inst[6:0];
  assign f3     = bus.inst[14:12];
  assign f7     = bus.inst[31:25];
  assign imm_i  = {{20{bus.inst[31]}}, bus.inst[31:20]};
  assign imm_s  = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
  assign imm_u  = {bus.inst[31:12], 12'b0};
  assign shamt  = {27'b0, bus.inst[24:20]};

  always_comb begin
    dec      = '0;
    dec.rd   = bus.inst[11:7];
    unique case (opcode)
      7'b0110011: begin
        dec.in1 = bus.rs1_data;
        dec.in2 = bus.rs2_data;
        unique case (f3)
          3'b000: dec.ctrl = (f7 == 7'h20) ? 5'd1 : 5'd0;
          3'b001: dec.ctrl = 5'd2;
          3'b010: dec.ctrl = 5'd3;
          3'b011: dec.ctrl = 5'd4;
          3'b100: dec.ctrl = 5'd5;
          3'b101: dec.ctrl = (f7 == 7'h20) ? 5'd7 : 5'd6;
          3'b110: dec.ctrl = 5'd8;
          default: dec.ctrl = 5'd9;
        endcase
        if (f7 != 7'h00 && f7 != 7'h20) dec.ill = 1'b1;
        if (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101) dec.ill = 1'b1;
      end
      7'b0010011: begin
        dec.in1 = bus.rs1_data;
        dec.in2 = imm_i;
        unique case (f3)
          3'b000: dec.ctrl = 5'd0;
          3'b001: begin
            dec.ctrl = 5'd2;
            dec.in2  = shamt;
            dec.ill  = (f7 != 7'h00);
          end
          3'b010: dec.ctrl = 5'd3;
          3'b011: dec.ctrl = 5'd4;
          3'b100: dec.ctrl = 5'd5;
          3'b101: begin
            dec.ctrl = bus.inst[30] ? 5'd7 : 5'd6;
            dec.in2  = shamt;
            dec.ill  = (f7 != 7'h00) && (f7 != 7'h20);
          end
          3'b110: dec.ctrl = 5'd8;
          default: dec.ctrl = 5'd9;
        endcase
      end
      7'b0000011: begin
        dec.in1 = bus.rs1_data;
        dec.in2 = imm_i;
      end
      7'b0100011: begin
        dec.in1 = bus.rs1_data;
        dec.in2 = imm_s;
        dec.rd  = '0;
      end
      7'b1100011: begin
        dec.in1 = bus.rs1_data;
        dec.in2 = bus.rs2_data;
        dec.br  = 1'b1;
        dec.rd  = '0;
        unique case (f3)
          3'b000: dec.ctrl = 5'd10;
          3'b001: dec.ctrl = 5'd11;
          3'b100: dec.ctrl = 5'd12;
          3'b101: dec.ctrl = 5'd13;
          3'b110: dec.ctrl = 5'd14;
          3'b111: dec.ctrl = 5'd15;
          default: dec.ill = 1'b1;
        endcase
      end
      7'b0010111: begin
        dec.in1 = bus.pc;
        dec.in2 = imm_u;
      end
      7'b1101111, 7'b1100111: begin
        dec.in1 = bus.pc;
        dec.in2 = 32'd4;
      end
      7'b0110111: begin
        dec.in2 = imm_u;
`ifdef ALU_LUI_PASS_EN
        dec.ctrl = 5'd16;
`else
        dec.ctrl = 5'd0;
`endif
      end
      default: dec.ill = 1'b1;
    endcase
    // Illegal entries still flow through, but carry no payload.
    if (dec.ill) begin
      dec     = '0;
      dec.ill = 1'b1;
    end
  end

  assign push = bus.in_valid && in_ready_q;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    count_nx = count;
    if (flush)
      count_nx = '0;
    else if (push && !pop)
      count_nx = count + 2'd1;
    else if (pop && !push)
      count_nx = count - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= '0;
      in_ready_q <= 1'b0;
      slot0      <= '0;
      slot1      <= '0;
    end else begin
      count      <= count_nx;
      in_ready_q <= (count_nx != FULL);
      if (!flush) begin
        // slot0 is always the head; a push during a pop at occupancy 1 replaces it directly.
        unique case (count)
          2'd0: if (push) slot0 <= dec;
          2'd1: begin
            if (push && pop) slot0 <= dec;
            else if (push)   slot1 <= dec;
          end
          default: if (pop) slot0 <= slot1;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (count != '0);
  assign bus.alu_ctrl  = slot0.ctrl;
  assign bus.alu_in1   = slot0.in1;
  assign bus.alu_in2   = slot0.in2;
  assign bus.rd        = slot0.rd;
  assign bus.is_branch = slot0.br;
  assign bus.illegal   = slot0.ill;
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed instructions, stall, flush and reset behaviour.
module tb_alu_issue;
  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  rd;
    logic        br;
    logic        ill;
  } exp_t;

  logic clk, rst_n, flush;
  int   pass_cnt = 0;
  int   total    = 0;
  exp_t q[$];

  alu_issue_if bus();

  alu_issue #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] r, input logic br, input logic ill);
    exp_t e;
    e.ctrl = c; e.in1 = a; e.in2 = b; e.rd = r; e.br = br; e.ill = ill;
    return e;
  endfunction

  task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                      input logic [31:0] b, input exp_t e);
    logic acc;
    acc = 1'b0;
    bus.inst = i; bus.pc = p; bus.rs1_data = a; bus.rs2_data = b;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc && !flush) q.push_back(e);
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  // Monitor: head is compared every cycle it is valid, so stalled fields must match too.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        if (q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else begin
          e = q[0];
          chk("alu_ctrl",  {27'b0, bus.alu_ctrl}, {27'b0, e.ctrl});
          chk("alu_in1",   bus.alu_in1, e.in1);
          chk("alu_in2",   bus.alu_in2, e.in2);
          chk("rd",        {27'b0, bus.rd}, {27'b0, e.rd});
          chk("is_branch", {31'b0, bus.is_branch}, {31'b0, e.br});
          chk("illegal",   {31'b0, bus.illegal}, {31'b0, e.ill});
          if (!flush && bus.out_ready) void'(q.pop_front());
        end
      end
      if (flush) q.delete();
    end
  end

  logic [4:0] lui_ctrl;

  initial begin
`ifdef ALU_LUI_PASS_EN
    lui_ctrl = 5'd16;
`else
    lui_ctrl = 5'd0;
`endif
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.inst = '0; bus.pc = '0; bus.rs1_data = '0; bus.rs2_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  {31'b0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_alu_ctrl",  {27'b0, bus.alu_ctrl}, 32'd0);
    chk("rst_in1",       bus.alu_in1, 32'd0);
    chk("rst_in2",       bus.alu_in2, 32'd0);
    chk("rst_rd",        {27'b0, bus.rd}, 32'd0);
    chk("rst_flags",     {30'b0, bus.is_branch, bus.illegal}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_first_cycle", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;

    // add x0,x1,x2
    send(32'h00208033, 32'h0, 32'd5, 32'd7, mk(5'd0, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0));
    @(negedge clk);
    chk("latency_out_valid", {31'b0, bus.out_valid}, 32'd1);
    @(posedge clk); #1;

    send(32'h40315093, 32'h0, 32'h80000000, 32'h0, mk(5'd7, 32'h80000000, 32'd3, 5'd1, 1'b0, 1'b0));
    send(32'h40311093, 32'h0, 32'h1, 32'h2, mk(5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1));
    send({7'h00, 5'd2, 5'd1, 3'b111, 5'd8, 7'h63}, 32'h0, 32'd1, 32'd2,
         mk(5'd15, 32'd1, 32'd2, 5'd0, 1'b1, 1'b0));
    send({7'h00, 5'd2, 5'd1, 3'b010, 5'd8, 7'h63}, 32'h0, 32'd1, 32'd2,
         mk(5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1));
    send({7'h20, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}, 32'h0, 32'd10, 32'd3,
         mk(5'd1, 32'd10, 32'd3, 5'd3, 1'b0, 1'b0));
    send({12'hFFF, 5'd1, 3'b000, 5'd4, 7'h13}, 32'h0, 32'd9, 32'd0,
         mk(5'd0, 32'd9, 32'hFFFFFFFF, 5'd4, 1'b0, 1'b0));
    send({7'h7F, 5'd2, 5'd1, 3'b010, 5'h1C, 7'h23}, 32'h0, 32'h1000, 32'd0,
         mk(5'd0, 32'h1000, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0));
    send({20'h00001, 5'd5, 7'h17}, 32'h100, 32'd0, 32'd0,
         mk(5'd0, 32'h100, 32'h1000, 5'd5, 1'b0, 1'b0));
    send({20'h00000, 5'd1, 7'h6F}, 32'h200, 32'd0, 32'd0,
         mk(5'd0, 32'h200, 32'd4, 5'd1, 1'b0, 1'b0));
    send(32'h0000007F, 32'h0, 32'd1, 32'd1, mk(5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1));
    send({7'h01, 5'd2, 5'd1, 3'b110, 5'd3, 7'h33}, 32'h0, 32'd1, 32'd1,
         mk(5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1));
    send(32'h123450B7, 32'h0, 32'hDEAD, 32'hBEEF, mk(lui_ctrl, 32'd0, 32'h12345000, 5'd1, 1'b0, 1'b0));

    // Stall: two beats fill the buffer, a third waits until out_ready rises.
    repeat (2) @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send({7'h00, 5'd2, 5'd1, 3'b100, 5'd6, 7'h33}, 32'h0, 32'hF0, 32'h0F,
         mk(5'd5, 32'hF0, 32'h0F, 5'd6, 1'b0, 1'b0));
    send({7'h00, 5'd2, 5'd1, 3'b111, 5'd7, 7'h33}, 32'h0, 32'h33, 32'h55,
         mk(5'd9, 32'h33, 32'h55, 5'd7, 1'b0, 1'b0));
    fork
      send({7'h00, 5'd2, 5'd1, 3'b101, 5'd8, 7'h33}, 32'h0, 32'h80, 32'd4,
           mk(5'd6, 32'h80, 32'd4, 5'd8, 1'b0, 1'b0));
      begin
        repeat (3) begin
          @(negedge clk);
          chk("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
          chk("full_out_valid", {31'b0, bus.out_valid}, 32'd1);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("stall_drained", q.size(), 32'd0);

    // Flush at occupancy 2 with a beat offered.
    bus.out_ready = 1'b0;
    send({7'h00, 5'd2, 5'd1, 3'b110, 5'd9, 7'h33}, 32'h0, 32'h1, 32'h2,
         mk(5'd8, 32'h1, 32'h2, 5'd9, 1'b0, 1'b0));
    send({7'h00, 5'd2, 5'd1, 3'b010, 5'd10, 7'h33}, 32'h0, 32'h3, 32'h4,
         mk(5'd3, 32'h3, 32'h4, 5'd10, 1'b0, 1'b0));
    bus.inst = {7'h00, 5'd2, 5'd1, 3'b011, 5'd11, 7'h33};
    bus.in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush2_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush2_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // Flush at occupancy 1 with an accepted-looking push: the push must vanish.
    send({7'h00, 5'd2, 5'd1, 3'b001, 5'd12, 7'h33}, 32'h0, 32'h5, 32'h6,
         mk(5'd2, 32'h5, 32'h6, 5'd12, 1'b0, 1'b0));
    bus.inst = {7'h00, 5'd2, 5'd1, 3'b100, 5'd13, 7'h33};
    bus.rs1_data = 32'hAA; bus.rs2_data = 32'hBB;
    bus.in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush1_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk); #1 flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush1_out_valid", {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    send({7'h00, 5'd2, 5'd1, 3'b000, 5'd14, 7'h33}, 32'h0, 32'h11, 32'h22,
         mk(5'd0, 32'h11, 32'h22, 5'd14, 1'b0, 1'b0));

    repeat (4) @(posedge clk); #1;
    chk("final_queue_empty", q.size(), 32'd0);
    chk("final_out_valid", {31'b0, bus.out_valid}, 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
